// File: rtl/dir_pkg.sv
// Shared encodings for the home-node directory controller: directory entry
// states, request/message opcodes and the control FSM state type.
package dir_pkg;

  // Directory entry state, bit-compatible with the cache-side encoding
  // (INVALID/UNCACHED 00, MODIFIED/EXCLUSIVE 01, SHARED 10).
  localparam logic [1:0] DIR_UNCACHED  = 2'b00;
  localparam logic [1:0] DIR_EXCLUSIVE = 2'b01;
  localparam logic [1:0] DIR_SHARED    = 2'b10;

  // Request opcodes from the caches.
  localparam logic [1:0] REQ_RESERVED   = 2'b00;
  localparam logic [1:0] REQ_READ_MISS  = 2'b01;
  localparam logic [1:0] REQ_WRITE_MISS = 2'b10;
  localparam logic [1:0] REQ_WRITE_BACK = 2'b11;

  // Message opcodes towards the caches.
  localparam logic [1:0] MSG_DATA_REPLY = 2'b00;
  localparam logic [1:0] MSG_INVALIDATE = 2'b01;
  localparam logic [1:0] MSG_FETCH      = 2'b10;
  localparam logic [1:0] MSG_FETCH_INV  = 2'b11;

  // Control FSM states.
  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_INV     = 3'd1,
    S_FETCH   = 3'd2,
    S_WAIT_WB = 3'd3,
    S_REPLY   = 3'd4
  } fsm_state_t;

endpackage

// File: rtl/directory_controller_if.sv
// Cache <-> directory bundle: request channel, message channel, write-back return.
// Handshake: a request or message transfers on any clock edge where both
// valid and ready are high; while valid is high and ready is low the sender
// keeps the payload stable.
interface directory_controller_if #(
  parameter int NODES  = 3,
  parameter int BLOCKS = 4
);
  localparam int NW = $clog2(NODES);
  localparam int BW = $clog2(BLOCKS);

  logic          req_valid;
  logic          req_ready;
  logic [1:0]    req_type;
  logic [NW-1:0] req_node;
  logic [BW-1:0] req_block;

  logic          msg_valid;
  logic          msg_ready;
  logic [1:0]    msg_type;
  logic [NW-1:0] msg_node;
  logic [BW-1:0] msg_block;

  logic          wb_valid;
  logic [NW-1:0] wb_node;

  // Cache side.
  modport master (
    output req_valid, req_type, req_node, req_block, msg_ready, wb_valid, wb_node,
    input  req_ready, msg_valid, msg_type, msg_node, msg_block
  );

  // Directory side.
  modport slave (
    input  req_valid, req_type, req_node, req_block, msg_ready, wb_valid, wb_node,
    output req_ready, msg_valid, msg_type, msg_node, msg_block
  );
endinterface

// File: rtl/dir_sharer_scan.sv
// Lowest-set-bit finder over a sharer mask: picks the next INVALIDATE target
// and decodes the one-hot owner of an EXCLUSIVE entry.
module dir_sharer_scan #(
  parameter int NODES = 3,
  parameter int NW    = $clog2(NODES)
) (
  input  logic [NODES-1:0] mask,
  output logic [NW-1:0]    idx,
  output logic             any
);

  // Scan from the top down so the lowest set index wins.
  always_comb begin
    idx = '0;
    any = 1'b0;
    for (int i = NODES - 1; i >= 0; i--) begin
      if (mask[i]) begin
        idx = NW'(i);
        any = 1'b1;
      end
    end
  end

endmodule

// File: rtl/directory_controller.sv
// Home-node directory controller: serves one READ_MISS / WRITE_MISS /
// WRITE_BACK at a time, sends INVALIDATE / FETCH / FETCH_INVALIDATE /
// DATA_REPLY messages and commits the entry when the DATA_REPLY completes.
module directory_controller
  import dir_pkg::*;
#(
  parameter int NODES  = 3,
  parameter int BLOCKS = 4
) (
  input  logic                             clock,
  input  logic                             reset,
  directory_controller_if.slave            bus,
  output fsm_state_t                       state_dbg,
  output logic [BLOCKS-1:0][1:0]           dir_state_dbg,
  output logic [BLOCKS-1:0][NODES-1:0]     sharers_dbg
);

  localparam int NW = $clog2(NODES);
  localparam int BW = $clog2(BLOCKS);

  // Directory storage.
  logic [1:0]       dir_state [BLOCKS];
  logic [NODES-1:0] sharers   [BLOCKS];

  fsm_state_t       state, nxt_state;
  logic [1:0]       lat_type;
  logic [NW-1:0]    lat_node;
  logic [BW-1:0]    lat_block;
  logic [NW-1:0]    owner;
  logic [NODES-1:0] pending;

  logic             accept, msg_hs;
  logic [1:0]       cur_state;
  logic [NODES-1:0] cur_sh, req_bit, lat_bit, tgt_bit, remaining;
  logic [NW-1:0]    cur_owner, inv_target;
  logic             cur_any, inv_any, cur_excl_other, cur_is_owner;

  assign accept    = bus.req_valid && bus.req_ready;
  assign msg_hs    = bus.msg_valid && bus.msg_ready;
  assign cur_state = dir_state[bus.req_block];
  assign cur_sh    = sharers[bus.req_block];
  assign req_bit   = NODES'(1) << bus.req_node;
  assign lat_bit   = NODES'(1) << lat_node;
  assign tgt_bit   = NODES'(1) << inv_target;
  assign remaining = pending & ~lat_bit & ~tgt_bit;

  assign cur_excl_other = (cur_state == DIR_EXCLUSIVE) && cur_any && (cur_owner != bus.req_node);
  assign cur_is_owner   = (cur_state == DIR_EXCLUSIVE) && cur_any && (cur_owner == bus.req_node);

  dir_sharer_scan #(.NODES(NODES), .NW(NW)) u_owner_scan (
    .mask (cur_sh),
    .idx  (cur_owner),
    .any  (cur_any)
  );

  dir_sharer_scan #(.NODES(NODES), .NW(NW)) u_inv_scan (
    .mask (pending & ~lat_bit),
    .idx  (inv_target),
    .any  (inv_any)
  );

  // FSM state register; reset aborts any transaction in flight.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) state <= S_IDLE;
    else       state <= nxt_state;
  end

  // Next-state decode.
  always_comb begin
    nxt_state = state;
    case (state)
      S_IDLE: begin
        if (accept) begin
          case (bus.req_type)
            REQ_READ_MISS:  nxt_state = cur_excl_other ? S_FETCH : S_REPLY;
            REQ_WRITE_MISS: begin
              if (cur_excl_other)
                nxt_state = S_FETCH;
              else if ((cur_state == DIR_SHARED) && |(cur_sh & ~req_bit))
                nxt_state = S_INV;
              else
                nxt_state = S_REPLY;
            end
            default:        nxt_state = S_IDLE;  // write-back and reserved finish at once
          endcase
        end
      end
      S_INV:     if (!inv_any || (msg_hs && !(|remaining))) nxt_state = S_REPLY;
      S_FETCH:   if (msg_hs) nxt_state = S_WAIT_WB;
      S_WAIT_WB: if (bus.wb_valid && (bus.wb_node == owner)) nxt_state = S_REPLY;
      S_REPLY:   if (msg_hs) nxt_state = S_IDLE;
      default:   nxt_state = S_IDLE;
    endcase
  end

  // Outputs decoded from registered state only, so they stay stable under back-pressure.
  always_comb begin
    bus.req_ready = (state == S_IDLE);
    bus.msg_valid = 1'b0;
    bus.msg_type  = MSG_DATA_REPLY;
    bus.msg_node  = '0;
    bus.msg_block = '0;
    case (state)
      S_INV: begin
        bus.msg_valid = inv_any;
        bus.msg_type  = MSG_INVALIDATE;
        bus.msg_node  = inv_target;
        bus.msg_block = lat_block;
      end
      S_FETCH: begin
        bus.msg_valid = 1'b1;
        bus.msg_type  = (lat_type == REQ_READ_MISS) ? MSG_FETCH : MSG_FETCH_INV;
        bus.msg_node  = owner;
        bus.msg_block = lat_block;
      end
      S_REPLY: begin
        bus.msg_valid = 1'b1;
        bus.msg_type  = MSG_DATA_REPLY;
        bus.msg_node  = lat_node;
        bus.msg_block = lat_block;
      end
      default: ;
    endcase
  end

  // Request latch, owner snapshot and pending-invalidate mask.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      lat_type  <= REQ_RESERVED;
      lat_node  <= '0;
      lat_block <= '0;
      owner     <= '0;
      pending   <= '0;
    end else if (accept) begin
      lat_type  <= bus.req_type;
      lat_node  <= bus.req_node;
      lat_block <= bus.req_block;
      owner     <= cur_owner;
      pending   <= cur_sh & ~req_bit;
    end else if ((state == S_INV) && msg_hs) begin
      pending   <= pending & ~tgt_bit;
    end
  end

  // Directory commit: write-back at acceptance, misses when DATA_REPLY completes.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int b = 0; b < BLOCKS; b++) begin
        dir_state[b] <= DIR_UNCACHED;
        sharers[b]   <= '0;
      end
    end else if (accept && (bus.req_type == REQ_WRITE_BACK) && cur_is_owner) begin
      dir_state[bus.req_block] <= DIR_UNCACHED;
      sharers[bus.req_block]   <= '0;
    end else if ((state == S_REPLY) && msg_hs) begin
      if (lat_type == REQ_READ_MISS) begin
        // Covers uncached, shared and fetched-owner cases alike.
        dir_state[lat_block] <= DIR_SHARED;
        sharers[lat_block]   <= sharers[lat_block] | lat_bit;
      end else begin
        dir_state[lat_block] <= DIR_EXCLUSIVE;
        sharers[lat_block]   <= lat_bit;
      end
    end
  end

  // Debug view of FSM and directory contents.
  assign state_dbg = state;
  always_comb begin
    for (int b = 0; b < BLOCKS; b++) begin
      dir_state_dbg[b] = dir_state[b];
      sharers_dbg[b]   = sharers[b];
    end
  end

endmodule

// File: tb/tb_directory_controller.sv
// Directed bench for directory_controller: hand-computed message sequences
// and directory contents for the read, write, fetch and write-back flows.
module tb_directory_controller;
  import dir_pkg::*;

  logic clock = 1'b0;
  logic reset;

  fsm_state_t      state_dbg;
  logic [3:0][1:0] dir_state_dbg;
  logic [3:0][2:0] sharers_dbg;

  directory_controller_if #(.NODES(3), .BLOCKS(4)) bus ();

  directory_controller #(.NODES(3), .BLOCKS(4)) dut (
    .clock         (clock),
    .reset         (reset),
    .bus           (bus),
    .state_dbg     (state_dbg),
    .dir_state_dbg (dir_state_dbg),
    .sharers_dbg   (sharers_dbg)
  );

  // Clock.
  always #5 clock = ~clock;

  int n_tests = 0;
  int n_fail  = 0;
  logic [5:0] exp_q[$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic expect_msg(input logic [1:0] t, input logic [1:0] n, input logic [1:0] b);
    exp_q.push_back({t, n, b});
  endtask

  task automatic wait_state(input fsm_state_t s, input string tag);
    int k;
    k = 0;
    while (state_dbg != s && k < 50) begin
      tick();
      k++;
    end
    if (state_dbg != s) check({tag, "_timeout"}, 32'(state_dbg), 32'(s));
  endtask

  // Issue one request; returns one cycle after acceptance (posedge + 1).
  task automatic do_req(input logic [1:0] t, input logic [1:0] n, input logic [1:0] b);
    wait_state(S_IDLE, "req_wait");
    bus.req_valid = 1'b1;
    bus.req_type  = t;
    bus.req_node  = n;
    bus.req_block = b;
    tick();
    bus.req_valid = 1'b0;
  endtask

  task automatic check_entry(input string tag, input int b, input logic [1:0] st, input logic [2:0] sh);
    check({tag, "_state"},   32'(dir_state_dbg[b]), 32'(st));
    check({tag, "_sharers"}, 32'(sharers_dbg[b]),   32'(sh));
  endtask

  // Scoreboard: every completed message must match the head of exp_q.
  always @(negedge clock) begin
    if (!reset && bus.msg_valid && bus.msg_ready) begin
      if (exp_q.size() == 0)
        check("msg_unexpected", 32'({bus.msg_type, bus.msg_node, bus.msg_block}), 32'hffff);
      else
        check("msg", 32'({bus.msg_type, bus.msg_node, bus.msg_block}), 32'(exp_q.pop_front()));
    end
  end

  initial begin
    reset         = 1'b1;
    bus.req_valid = 1'b0;
    bus.req_type  = 2'b00;
    bus.req_node  = 2'd0;
    bus.req_block = 2'd0;
    bus.msg_ready = 1'b1;
    bus.wb_valid  = 1'b0;
    bus.wb_node   = 2'd0;
    tick();
    tick();
    reset = 1'b0;
    tick();

    // Reset state.
    check("rst_state", 32'(state_dbg), 32'(S_IDLE));
    check("rst_req_ready", 32'(bus.req_ready), 32'd1);
    check("rst_msg_valid", 32'(bus.msg_valid), 32'd0);
    check("rst_msg_fields", 32'({bus.msg_type, bus.msg_node, bus.msg_block}), 32'd0);
    for (int b = 0; b < 4; b++) check_entry("rst_entry", b, DIR_UNCACHED, 3'b000);

    // Uncached read: reply at cycle 1, ready again at cycle 2.
    expect_msg(MSG_DATA_REPLY, 2'd0, 2'd2);
    do_req(REQ_READ_MISS, 2'd0, 2'd2);
    check("t1_msg_valid", 32'(bus.msg_valid), 32'd1);
    check("t1_msg_fields", 32'({bus.msg_type, bus.msg_node, bus.msg_block}), 32'({MSG_DATA_REPLY, 2'd0, 2'd2}));
    check("t1_req_ready_busy", 32'(bus.req_ready), 32'd0);
    tick();
    check("t1_req_ready_back", 32'(bus.req_ready), 32'd1);
    check_entry("t1_entry2", 2, DIR_SHARED, 3'b001);

    // Two readers then a writer: invalidate 0, invalidate 1, reply 2.
    expect_msg(MSG_DATA_REPLY, 2'd0, 2'd1);
    do_req(REQ_READ_MISS, 2'd0, 2'd1);
    expect_msg(MSG_DATA_REPLY, 2'd1, 2'd1);
    do_req(REQ_READ_MISS, 2'd1, 2'd1);
    wait_state(S_IDLE, "t2_reads");
    check_entry("t2_shared", 1, DIR_SHARED, 3'b011);
    expect_msg(MSG_INVALIDATE, 2'd0, 2'd1);
    expect_msg(MSG_INVALIDATE, 2'd1, 2'd1);
    expect_msg(MSG_DATA_REPLY, 2'd2, 2'd1);
    bus.msg_ready = 1'b0;
    do_req(REQ_WRITE_MISS, 2'd2, 2'd1);
    for (int i = 0; i < 3; i++) begin
      check("t2_hold_valid", 32'(bus.msg_valid), 32'd1);
      check("t2_hold_fields", 32'({bus.msg_type, bus.msg_node, bus.msg_block}), 32'({MSG_INVALIDATE, 2'd0, 2'd1}));
      tick();
    end
    bus.msg_ready = 1'b1;
    wait_state(S_IDLE, "t2_write");
    check_entry("t2_excl", 1, DIR_EXCLUSIVE, 3'b100);

    // Read of a block owned elsewhere: fetch, ignore a foreign write-back.
    expect_msg(MSG_DATA_REPLY, 2'd1, 2'd3);
    do_req(REQ_WRITE_MISS, 2'd1, 2'd3);
    wait_state(S_IDLE, "t3_own");
    check_entry("t3_owned", 3, DIR_EXCLUSIVE, 3'b010);
    expect_msg(MSG_FETCH, 2'd1, 2'd3);
    expect_msg(MSG_DATA_REPLY, 2'd0, 2'd3);
    do_req(REQ_READ_MISS, 2'd0, 2'd3);
    wait_state(S_WAIT_WB, "t3_fetch");
    bus.wb_valid = 1'b1;
    bus.wb_node  = 2'd2;
    tick();
    check("t3_foreign_wb_state", 32'(state_dbg), 32'(S_WAIT_WB));
    check("t3_foreign_wb_msg_valid", 32'(bus.msg_valid), 32'd0);
    bus.wb_node = 2'd1;
    tick();
    bus.wb_valid = 1'b0;
    check("t3_wb_to_reply", 32'(state_dbg), 32'(S_REPLY));
    wait_state(S_IDLE, "t3_reply");
    check_entry("t3_shared", 3, DIR_SHARED, 3'b011);

    // Write to a block owned elsewhere: fetch-invalidate.
    expect_msg(MSG_DATA_REPLY, 2'd0, 2'd0);
    do_req(REQ_WRITE_MISS, 2'd0, 2'd0);
    expect_msg(MSG_FETCH_INV, 2'd0, 2'd0);
    expect_msg(MSG_DATA_REPLY, 2'd2, 2'd0);
    do_req(REQ_WRITE_MISS, 2'd2, 2'd0);
    wait_state(S_WAIT_WB, "t4_fetch");
    bus.wb_valid = 1'b1;
    bus.wb_node  = 2'd0;
    tick();
    bus.wb_valid = 1'b0;
    wait_state(S_IDLE, "t4_reply");
    check_entry("t4_excl", 0, DIR_EXCLUSIVE, 3'b100);

    // Write-backs: stale one dropped, owner's one uncaches the block.
    do_req(REQ_WRITE_BACK, 2'd1, 2'd0);
    check("t5_stale_msg_valid", 32'(bus.msg_valid), 32'd0);
    check("t5_stale_ready", 32'(bus.req_ready), 32'd1);
    check_entry("t5_stale", 0, DIR_EXCLUSIVE, 3'b100);
    do_req(REQ_WRITE_BACK, 2'd2, 2'd0);
    check("t5_wb_ready", 32'(bus.req_ready), 32'd1);
    check_entry("t5_wb", 0, DIR_UNCACHED, 3'b000);

    // Reset while waiting for a write-back.
    expect_msg(MSG_INVALIDATE, 2'd0, 2'd2);
    expect_msg(MSG_DATA_REPLY, 2'd1, 2'd2);
    do_req(REQ_WRITE_MISS, 2'd1, 2'd2);
    wait_state(S_IDLE, "t6_own");
    check_entry("t6_owned", 2, DIR_EXCLUSIVE, 3'b010);
    expect_msg(MSG_FETCH, 2'd1, 2'd2);
    do_req(REQ_READ_MISS, 2'd2, 2'd2);
    wait_state(S_WAIT_WB, "t6_fetch");
    check("t6_queue_drained", 32'(exp_q.size()), 32'd0);
    #2;
    reset = 1'b1;
    #1;
    check("t6_rst_msg_valid", 32'(bus.msg_valid), 32'd0);
    check("t6_rst_req_ready", 32'(bus.req_ready), 32'd1);
    check("t6_rst_state", 32'(state_dbg), 32'(S_IDLE));
    for (int b = 0; b < 4; b++) check_entry("t6_rst_entry", b, DIR_UNCACHED, 3'b000);
    tick();
    reset = 1'b0;
    tick();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/directory_controller.md
# directory_controller

Home-node directory controller for the directory-based coherence protocol; the other end of the per-cache-block FSM. It accepts READ_MISS / WRITE_MISS / WRITE_BACK requests from the caches and tracks per-block directory state and sharer sets. It issues INVALIDATE, FETCH, FETCH_INVALIDATE and DATA_REPLY messages back to the caches, one request at a time.

## Interface
- NODES, 3, number of caches; node IDs 0..NODES-1
- BLOCKS, 4, number of directory entries; block IDs 0..BLOCKS-1
- NW = $clog2(NODES), BW = $clog2(BLOCKS) (derived, not overridable)

- clock  in  1  single clock, rising edge
- reset  in  1  asynchronous, active-high
- req_valid  in  1  request present
- req_ready  out  1  controller can accept; = (fsm == IDLE)
- req_type  in  2  01 READ_MISS, 10 WRITE_MISS, 11 WRITE_BACK, 00 reserved
- req_node  in  NW  requesting cache
- req_block  in  BW  block addressed
- msg_valid  out  1  outgoing message present
- msg_ready  in  1  message consumed
- msg_type  out  2  00 DATA_REPLY, 01 INVALIDATE, 10 FETCH, 11 FETCH_INVALIDATE
- msg_node  out  NW  destination cache
- msg_block  out  BW  block addressed
- wb_valid  in  1  owner data returned after FETCH / FETCH_INVALIDATE
- wb_node  in  NW  node returning data

## Operation
- Per entry: dir_state (UNCACHED 00, EXCLUSIVE 01, SHARED 10) plus sharers[NODES]. In EXCLUSIVE, sharers is one-hot and marks the owner.
- Control FSM states: IDLE, INV, FETCH, WAIT_WB, REPLY.
- IDLE: a request is accepted on req_valid && req_ready. Type, node and block are latched. The entry is read at acceptance.
- READ_MISS handling:
  - UNCACHED → REPLY. Commit SHARED, sharers={req}.
  - SHARED → REPLY. Commit sharers |= req.
  - EXCLUSIVE, owner≠req → FETCH (type FETCH to owner), then WAIT_WB, then REPLY. Commit SHARED, sharers={owner,req}.
  - EXCLUSIVE, owner==req → handled as UNCACHED.
- WRITE_MISS handling (this also covers a sharer's upgrade on a write hit):
  - UNCACHED → REPLY. Commit EXCLUSIVE, sharers={req}.
  - SHARED → INV: one INVALIDATE per sharer, excluding req, in ascending node order, one per handshake. Then REPLY. If no sharer other than req exists, go directly to REPLY. Commit EXCLUSIVE, sharers={req}.
  - EXCLUSIVE, owner≠req → FETCH (type FETCH_INVALIDATE), then WAIT_WB, then REPLY. Commit EXCLUSIVE, sharers={req}.
- WRITE_BACK handling:
  - Only when EXCLUSIVE and req is the owner: commit UNCACHED, sharers=0, with no message.
  - Otherwise the request is stale and dropped.
  - In either case, return to IDLE next cycle.
- Reserved type 00: accepted and dropped; return to IDLE next cycle.
- WAIT_WB: msg_valid=0. Leave on wb_valid && wb_node==owner. A wb_valid from any other node is ignored.
- Directory commit occurs in the cycle the DATA_REPLY handshake completes. Entries are never modified mid-transaction.

## Timing
- Reset values: FSM IDLE, req_ready 1, msg_valid 0, msg_type 00, msg_node 0, msg_block 0. All entries are UNCACHED with sharers 0. Reset mid-transaction aborts immediately with no commit.
- msg_* are registered. The first message is valid in the cycle after acceptance.
- A message completes on msg_valid && msg_ready. msg_type/node/block are held stable while msg_valid && !msg_ready.
- The next message (next INVALIDATE, or REPLY) is valid in the cycle after the handshake. After the REPLY handshake, the FSM is in IDLE the next cycle.
- Minimum latency: UNCACHED read is accepted at cycle 0, REPLY is valid at cycle 1, and req_ready is back at cycle 2. Throughput is 1 request per 2 cycles.
- WAIT_WB → REPLY: REPLY is valid in the cycle after the matching wb_valid.
- req_ready=0 outside IDLE; requests stall upstream.

## Structure
- Package dir_pkg holds:
  - Directory state encodings, matching the cache-side 2-bit encoding (INVALID/UNCACHED 00, MODIFIED/EXCLUSIVE 01, SHARED 10).
  - Request and message type localparams.
  - FSM state enum.
- Sub-module dir_sharer_scan is combinational. Input is a NODES-bit mask; outputs are the lowest set index and an any-set flag. It selects the next INVALIDATE target from (pending mask & ~req bit), and the pending bit is cleared on each handshake.
- Entry storage consists of flat register arrays inside directory_controller.

## Test plan
- Reset, then READ_MISS node 0 block 2 with msg_ready=1 → DATA_REPLY to node 0 at cycle 1; entry 2 = SHARED, sharers 001; req_ready high at cycle 2.
- Reads by nodes 0 and 1 on block 1, then WRITE_MISS node 2 block 1 → INVALIDATE to node 0, then to node 1, then DATA_REPLY to node 2; entry = EXCLUSIVE, sharers 100. Hold msg_ready=0 for 3 cycles on the first INVALIDATE and check outputs are stable.
- Block 3 EXCLUSIVE at node 1, READ_MISS node 0 → FETCH to node 1. A wb_valid from node 2 is ignored. After wb_valid from node 1 → DATA_REPLY to node 0; entry = SHARED, sharers 011.
- Block 0 EXCLUSIVE at node 0, WRITE_MISS node 2 → FETCH_INVALIDATE to node 0, wb from 0, DATA_REPLY to 2; sharers 100.
- WRITE_BACK from non-owner node 1 on block 0 (owner 2) → no message, entry unchanged. WRITE_BACK from node 2 → entry UNCACHED, sharers 000.
- Assert reset while in WAIT_WB → msg_valid 0 and req_ready 1 immediately; all entries UNCACHED.
